rv_test_sequencer: RTL

Synthesisable on-chip test sequencer for the RV32IC core-plus-memory top. It runs NUM_TESTS back-to-back test cases from a descriptor source. For each case it holds the core in reset, releases it for a bounded run, then reads one result word from data memory and compares it with an expected value. It accumulates pass/fail status per test, so a whole regression runs in hardware with no host intervention between tests.

---
 rtl/rv_test_sequencer_if.sv | 28 ++
 rtl/rv_test_sequencer.sv | 137 +++++++++++++
 2 files changed

// File: rtl/rv_test_sequencer_if.sv
// Descriptor, core-control and data-memory signals between the test sequencer
// and the core-plus-memory harness.
interface rv_test_sequencer_if #(
   parameter int TEST_W = 3,
   parameter int CNT_W  = 16,
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic [TEST_W-1:0] desc_idx;
   logic [CNT_W-1:0]  desc_cycles;
   logic [ADDR_W-1:0] desc_addr;
   logic [DATA_W-1:0] desc_expected;
   logic              core_rst_n;
   logic              core_halt;
   logic              mem_rd_en;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_rdata;

   modport master (
      output desc_idx, core_rst_n, mem_rd_en, mem_addr,
      input  desc_cycles, desc_addr, desc_expected, core_halt, mem_rdata
   );

   modport slave (
      input  desc_idx, core_rst_n, mem_rd_en, mem_addr,
      output desc_cycles, desc_addr, desc_expected, core_halt, mem_rdata
   );
endinterface

// File: rtl/rv_test_sequencer.sv
// On-chip regression sequencer: resets the core, runs it for a bounded time,
// reads one result word and accumulates pass/fail/timeout status per test.
module rv_test_sequencer #(
   parameter int  NUM_TESTS    = 8,
   parameter int  DATA_W       = 32,
   parameter int  ADDR_W       = 32,
   parameter int  CNT_W        = 16,
   parameter int  RESET_CYCLES = 4,
   localparam int TEST_W       = (NUM_TESTS > 1) ? $clog2(NUM_TESTS) : 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic                 abort,
   rv_test_sequencer_if.master  bus,
   output logic                 busy,
   output logic                 done,
   output logic [TEST_W-1:0]    cur_test,
   output logic [TEST_W:0]      pass_cnt,
   output logic [TEST_W:0]      fail_cnt,
   output logic [NUM_TESTS-1:0] fail_mask,
   output logic [NUM_TESTS-1:0] timeout_mask
);

   localparam int RC_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;

   typedef enum logic [2:0] {
      S_IDLE, S_RESET, S_RUN, S_READ, S_CHECK, S_DONE
   } state_t;

   state_t            state_q, state_d;
   logic [RC_W-1:0]   rst_cnt;
   logic [CNT_W-1:0]  run_cnt;
   logic [CNT_W-1:0]  lat_cycles;
   logic [ADDR_W-1:0] lat_addr;
   logic [DATA_W-1:0] lat_expected;
   logic              timed_out;

   logic rst_last, budget_hit, last_test, start_ok, test_pass;

   assign rst_last   = (rst_cnt == RC_W'(RESET_CYCLES - 1));
   assign budget_hit = (lat_cycles != '0) && (run_cnt == lat_cycles - 1'b1);
   assign last_test  = (cur_test == TEST_W'(NUM_TESTS - 1));
   assign start_ok   = start && !abort && (state_q == S_IDLE || state_q == S_DONE);
   assign test_pass  = (bus.mem_rdata == lat_expected) && !timed_out;

   assign bus.desc_idx = cur_test;
   assign bus.mem_addr = lat_addr;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   // NOTE: every output of this block gets a default first, so no path
   // through the case statement can infer a latch.
   always_comb begin
      state_d        = state_q;
      bus.core_rst_n = 1'b0;
      bus.mem_rd_en  = 1'b0;
      busy           = 1'b1;
      done           = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            busy = 1'b0;
            if (start) state_d = S_RESET;
         end
         S_RESET: if (rst_last) state_d = S_RUN;
         S_RUN: begin
            bus.core_rst_n = 1'b1;
            if (bus.core_halt || budget_hit) state_d = S_READ;
         end
         S_READ: begin
            bus.mem_rd_en = 1'b1;
            state_d       = S_CHECK;
         end
         S_CHECK: state_d = last_test ? S_DONE : S_RESET;
         S_DONE: begin
            busy = 1'b0;
            done = 1'b1;
            if (start) state_d = S_RESET;
         end
         default: state_d = S_IDLE;
      endcase
      if (abort) state_d = S_IDLE;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rst_cnt      <= '0;
         run_cnt      <= '0;
         lat_cycles   <= '0;
         lat_addr     <= '0;
         lat_expected <= '0;
         timed_out    <= 1'b0;
         cur_test     <= '0;
         pass_cnt     <= '0;
         fail_cnt     <= '0;
         fail_mask    <= '0;
         timeout_mask <= '0;
      end else begin
         rst_cnt <= (state_q == S_RESET) ? rst_cnt + 1'b1 : '0;
         run_cnt <= (state_q == S_RUN)   ? run_cnt + 1'b1 : '0;

         // desc_idx only shows the new cur_test once RESET has been entered,
         // so the descriptor is captured during the first RESET cycle.
         if (state_q == S_RESET && rst_cnt == '0) begin
            lat_cycles   <= bus.desc_cycles;
            lat_addr     <= bus.desc_addr;
            lat_expected <= bus.desc_expected;
         end

         // Halt takes priority: a coincident budget expiry is not a timeout.
         if (state_q == S_RUN) timed_out <= budget_hit && !bus.core_halt;

         if (start_ok) begin
            cur_test     <= '0;
            pass_cnt     <= '0;
            fail_cnt     <= '0;
            fail_mask    <= '0;
            timeout_mask <= '0;
         end else if (state_q == S_CHECK && !abort) begin
            if (test_pass) begin
               pass_cnt <= pass_cnt + 1'b1;
            end else begin
               fail_cnt            <= fail_cnt + 1'b1;
               fail_mask[cur_test] <= 1'b1;
            end
            if (timed_out) timeout_mask[cur_test] <= 1'b1;
            if (!last_test) cur_test <= cur_test + 1'b1;
         end
      end
   end

endmodule
